// File: rtl/lsu_pkg.sv
// Shared ISA constants, FSM state and lane-size types for the load/store unit.
package lsu_pkg;

  localparam int isa_xlen = 32;

  localparam logic [2:0] isa_funct3_lb  = 3'd0;
  localparam logic [2:0] isa_funct3_lh  = 3'd1;
  localparam logic [2:0] isa_funct3_lw  = 3'd2;
  localparam logic [2:0] isa_funct3_lbu = 3'd4;
  localparam logic [2:0] isa_funct3_lhu = 3'd5;
  localparam logic [2:0] isa_funct3_sb  = 3'd0;
  localparam logic [2:0] isa_funct3_sh  = 3'd1;
  localparam logic [2:0] isa_funct3_sw  = 3'd2;

  typedef enum logic [1:0] {
    st_idle,
    st_bus,
    st_resp
  } lsu_state_e;

  typedef enum logic [1:0] {
    size_byte,
    size_half,
    size_word
  } lane_size_e;

  // Access size lives in the low two funct3 bits; bit 2 only selects zero-extension.
  function automatic lane_size_e funct3_size(input logic [1:0] f);
    case (f)
      2'd0:    return size_byte;
      2'd1:    return size_half;
      default: return size_word;
    endcase
  endfunction

  function automatic logic funct3_illegal(input logic write, input logic [2:0] f);
    if (write) return (f >= 3'd3);
    return (f == 3'd3) || (f >= 3'd6);
  endfunction

  function automatic logic addr_misaligned(input lane_size_e s, input logic [1:0] off);
    case (s)
      size_half: return off[0];
      size_word: return (off != 2'd0);
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request, data-bus and response signals of the load/store unit.
interface lsu_if #(
  parameter int Width = 32
);
  logic               req_valid;
  logic               req_ready;
  logic               req_write;
  logic [2:0]         req_funct3;
  logic [Width-1:0]   req_addr;
  logic [Width-1:0]   req_wdata;

  logic               mem_req;
  logic               mem_we;
  logic [Width-1:0]   mem_addr;
  logic [Width/8-1:0] mem_be;
  logic [Width-1:0]   mem_wdata;
  logic               mem_ack;
  logic [Width-1:0]   mem_rdata;

  logic               rsp_valid;
  logic [Width-1:0]   rsp_data;
  logic               rsp_misaligned;
  logic               rsp_illegal;
  logic               rsp_timeout;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  mem_ack, mem_rdata,
    output req_ready,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output rsp_valid, rsp_data, rsp_misaligned, rsp_illegal, rsp_timeout
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    output mem_ack, mem_rdata,
    input  req_ready,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  rsp_valid, rsp_data, rsp_misaligned, rsp_illegal, rsp_timeout
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte enables/replication and load shift-plus-extend.
module lsu_align
  import lsu_pkg::*;
(
  input  lane_size_e  size,
  input  logic        unsigned_ld,
  input  logic        write,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    be = 4'b1111;
    if (write) begin
      case (size)
        size_byte: be = 4'b0001 << off;
        size_half: be = 4'b0011 << off;
        default:   be = 4'b1111;
      endcase
    end
  end

  // Every lane carries the store data so the slave picks it up wherever be points.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign wdata_rep[8*gi +: 8] = (size == size_byte) ? wdata[7:0] :
                                  (size == size_half) ? wdata[8*(gi%2) +: 8] :
                                                        wdata[8*gi +: 8];
  end

  assign shifted = rdata >> {off, 3'b000};

  always_comb begin
    case (size)
      size_byte: load_data = {{24{shifted[7]  & ~unsigned_ld}}, shifted[7:0]};
      size_half: load_data = {{16{shifted[15] & ~unsigned_ld}}, shifted[15:0]};
      default:   load_data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one single-beat word access per op, with fault detection and bus timeout.
module lsu
  import lsu_pkg::*;
#(
  parameter int Width         = isa_xlen,
  parameter int TimeoutCycles = 16
) (
  input  logic  clk,
  input  logic  rst_n,
  lsu_if.slave  io
);

  if (Width != 32) begin : g_bad_width
    $error("lsu: only Width = 32 is supported");
  end
  if (TimeoutCycles < 1) begin : g_bad_timeout
    $error("lsu: TimeoutCycles must be >= 1");
  end

  localparam int CntW = $clog2(TimeoutCycles + 1);

  lsu_state_e      state_reg, state_next;
  logic [CntW-1:0] cnt_reg, cnt_next;
  logic [31:0]     data_reg, data_next;
  logic            illegal_reg, illegal_next;
  logic            misaligned_reg, misaligned_next;
  logic            timeout_reg, timeout_next;

  logic            write_reg;
  logic [2:0]      funct3_reg;
  logic [31:0]     addr_reg;
  logic [31:0]     wdata_reg;

  logic            accept;
  logic            req_illegal;
  logic            req_misaligned;
  logic [3:0]      be;
  logic [31:0]     wdata_rep;
  logic [31:0]     load_data;

  assign accept         = io.req_valid && (state_reg == st_idle);
  assign req_illegal    = funct3_illegal(io.req_write, io.req_funct3);
  assign req_misaligned = addr_misaligned(funct3_size(io.req_funct3[1:0]), io.req_addr[1:0]);

  lsu_align u_align (
    .size        (funct3_size(funct3_reg[1:0])),
    .unsigned_ld (funct3_reg[2]),
    .write       (write_reg),
    .off         (addr_reg[1:0]),
    .wdata       (wdata_reg),
    .rdata       (io.mem_rdata),
    .be          (be),
    .wdata_rep   (wdata_rep),
    .load_data   (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= st_idle;
      cnt_reg        <= '0;
      data_reg       <= '0;
      illegal_reg    <= 1'b0;
      misaligned_reg <= 1'b0;
      timeout_reg    <= 1'b0;
      write_reg      <= 1'b0;
      funct3_reg     <= '0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      data_reg       <= data_next;
      illegal_reg    <= illegal_next;
      misaligned_reg <= misaligned_next;
      timeout_reg    <= timeout_next;
      if (accept) begin
        write_reg  <= io.req_write;
        funct3_reg <= io.req_funct3;
        addr_reg   <= io.req_addr;
        wdata_reg  <= io.req_wdata;
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    data_next       = data_reg;
    illegal_next    = illegal_reg;
    misaligned_next = misaligned_reg;
    timeout_next    = timeout_reg;
    case (state_reg)
      st_idle: begin
        if (accept) begin
          cnt_next        = '0;
          data_next       = '0;
          timeout_next    = 1'b0;
          illegal_next    = req_illegal;
          misaligned_next = !req_illegal && req_misaligned;
          state_next      = (req_illegal || req_misaligned) ? st_resp : st_bus;
        end
      end
      st_bus: begin
        // An ack in the final allowed cycle still wins over the timeout.
        if (io.mem_ack) begin
          data_next  = write_reg ? 32'd0 : load_data;
          state_next = st_resp;
        end else if (cnt_reg == CntW'(TimeoutCycles - 1)) begin
          timeout_next = 1'b1;
          state_next   = st_resp;
        end else begin
          cnt_next = cnt_reg + CntW'(1);
        end
      end
      st_resp: state_next = st_idle;
      default: state_next = st_idle;
    endcase
  end

  assign io.req_ready      = (state_reg == st_idle);

  assign io.mem_req        = (state_reg == st_bus);
  assign io.mem_we         = io.mem_req && write_reg;
  assign io.mem_addr       = io.mem_req ? {addr_reg[31:2], 2'b00} : '0;
  assign io.mem_be         = io.mem_req ? be : '0;
  assign io.mem_wdata      = io.mem_req ? wdata_rep : '0;

  assign io.rsp_valid      = (state_reg == st_resp);
  assign io.rsp_data       = io.rsp_valid ? data_reg : '0;
  assign io.rsp_illegal    = io.rsp_valid && illegal_reg;
  assign io.rsp_misaligned = io.rsp_valid && misaligned_reg;
  assign io.rsp_timeout    = io.rsp_valid && timeout_reg;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: aligned loads/stores, faults, timeout and mid-bus reset.
module tb_lsu;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  lsu_if #(.Width(32)) io ();

  lsu #(.Width(32), .TimeoutCycles(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the request is accepted at the following posedge.
  task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    io.req_valid  = 1'b1;
    io.req_write  = wr;
    io.req_funct3 = f3;
    io.req_addr   = a;
    io.req_wdata  = wd;
    @(negedge clk);
    io.req_valid  = 1'b0;
  endtask

  task automatic bus_op(input string tag, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wd, input logic [31:0] exp_rsp);
    issue(wr, f3, a, wd);
    chk({tag, ".mem_req"},  32'(io.mem_req), 32'd1);
    chk({tag, ".mem_we"},   32'(io.mem_we), 32'(wr));
    chk({tag, ".mem_addr"}, io.mem_addr, exp_addr);
    chk({tag, ".mem_be"},   32'(io.mem_be), 32'(exp_be));
    if (wr) chk({tag, ".mem_wdata"}, io.mem_wdata, exp_wd);
    io.mem_ack   = 1'b1;
    io.mem_rdata = rd;
    @(negedge clk);
    io.mem_ack   = 1'b0;
    chk({tag, ".rsp_valid"}, 32'(io.rsp_valid), 32'd1);
    chk({tag, ".rsp_data"},  io.rsp_data, exp_rsp);
    chk({tag, ".flags"}, 32'({io.rsp_misaligned, io.rsp_illegal, io.rsp_timeout}), 32'd0);
    @(negedge clk);
    chk({tag, ".rsp_drop"}, 32'(io.rsp_valid), 32'd0);
    chk({tag, ".ready"},    32'(io.req_ready), 32'd1);
    $display("op %s addr=%h rsp=%h", tag, a, exp_rsp);
  endtask

  // exp_flags = {misaligned, illegal, timeout}
  task automatic fault_op(input string tag, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [2:0] exp_flags);
    issue(wr, f3, a, 32'h1111_2222);
    chk({tag, ".mem_req"},   32'(io.mem_req), 32'd0);
    chk({tag, ".rsp_valid"}, 32'(io.rsp_valid), 32'd1);
    chk({tag, ".flags"}, 32'({io.rsp_misaligned, io.rsp_illegal, io.rsp_timeout}), 32'(exp_flags));
    chk({tag, ".rsp_data"},  io.rsp_data, 32'd0);
    @(negedge clk);
    chk({tag, ".rsp_drop"}, 32'(io.rsp_valid), 32'd0);
    chk({tag, ".ready"},    32'(io.req_ready), 32'd1);
    $display("op %s addr=%h flags=%b", tag, a, exp_flags);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  done;
    rst_n         = 1'b1;
    io.req_valid  = 1'b0;
    io.req_write  = 1'b0;
    io.req_funct3 = 3'd0;
    io.req_addr   = '0;
    io.req_wdata  = '0;
    io.mem_ack    = 1'b0;
    io.mem_rdata  = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.ready", 32'(io.req_ready), 32'd1);
    chk("rst.mem", 32'({io.mem_req, io.mem_we, io.mem_be}), 32'd0);
    chk("rst.mem_addr", io.mem_addr, 32'd0);
    chk("rst.mem_wdata", io.mem_wdata, 32'd0);
    chk("rst.rsp", 32'({io.rsp_valid, io.rsp_misaligned, io.rsp_illegal, io.rsp_timeout}), 32'd0);
    chk("rst.rsp_data", io.rsp_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    bus_op("lw",  0, isa_funct3_lw,  32'h1000_0004, 32'h0, 32'hDEAD_BEEF, 32'h1000_0004, 4'hF, 32'h0, 32'hDEAD_BEEF);
    bus_op("lb",  0, isa_funct3_lb,  32'h0000_0103, 32'h0, 32'h80FF_0000, 32'h0000_0100, 4'hF, 32'h0, 32'hFFFF_FF80);
    bus_op("lbu", 0, isa_funct3_lbu, 32'h0000_0103, 32'h0, 32'h80FF_0000, 32'h0000_0100, 4'hF, 32'h0, 32'h0000_0080);
    bus_op("lh",  0, isa_funct3_lh,  32'h0000_0102, 32'h0, 32'h80FF_0000, 32'h0000_0100, 4'hF, 32'h0, 32'hFFFF_80FF);
    bus_op("lhu", 0, isa_funct3_lhu, 32'h0000_0100, 32'h0, 32'h1234_F00D, 32'h0000_0100, 4'hF, 32'h0, 32'h0000_F00D);
    bus_op("sh",  1, isa_funct3_sh,  32'h0000_2002, 32'h1234_ABCD, 32'h0, 32'h0000_2000, 4'hC, 32'hABCD_ABCD, 32'h0);
    bus_op("sb",  1, isa_funct3_sb,  32'h0000_3001, 32'h0000_0055, 32'h0, 32'h0000_3000, 4'h2, 32'h5555_5555, 32'h0);
    bus_op("sw",  1, isa_funct3_sw,  32'h0000_4000, 32'hCAFE_F00D, 32'h0, 32'h0000_4000, 4'hF, 32'hCAFE_F00D, 32'h0);

    fault_op("lw_mis",  0, isa_funct3_lw, 32'h0000_2001, 3'b100);
    fault_op("lh_mis",  0, isa_funct3_lh, 32'h0000_0101, 3'b100);
    fault_op("st_ill",  1, 3'd3,          32'h0000_2000, 3'b010);
    fault_op("ld_prio", 0, 3'd3,          32'h0000_0001, 3'b010);

    // No ack at all: mem_req must be held for exactly 16 cycles.
    issue(0, isa_funct3_lw, 32'h0000_0500, 32'h0);
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (io.mem_req) n++;
      if (io.rsp_valid) done = 1'b1;
      else @(negedge clk);
    end
    chk("to.done", 32'(done), 32'd1);
    chk("to.req_cycles", 32'(n), 32'd16);
    chk("to.flags", 32'({io.rsp_misaligned, io.rsp_illegal, io.rsp_timeout}), 32'd1);
    chk("to.rsp_data", io.rsp_data, 32'd0);
    $display("op timeout req_cycles=%0d", n);
    @(negedge clk);
    io.mem_ack   = 1'b1;
    io.mem_rdata = 32'h5A5A_5A5A;
    repeat (2) begin
      @(negedge clk);
      chk("stray.rsp_valid", 32'(io.rsp_valid), 32'd0);
      chk("stray.mem_req", 32'(io.mem_req), 32'd0);
    end
    io.mem_ack = 1'b0;
    bus_op("lw_after", 0, isa_funct3_lw, 32'h0000_0700, 32'h0, 32'h0123_4567, 32'h0000_0700, 4'hF, 32'h0, 32'h0123_4567);

    // Ack arriving in the 16th and last request cycle is a success.
    issue(0, isa_funct3_lw, 32'h0000_0800, 32'h0);
    repeat (15) @(negedge clk);
    chk("last.mem_req", 32'(io.mem_req), 32'd1);
    io.mem_ack   = 1'b1;
    io.mem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    io.mem_ack = 1'b0;
    chk("last.rsp_valid", 32'(io.rsp_valid), 32'd1);
    chk("last.flags", 32'({io.rsp_misaligned, io.rsp_illegal, io.rsp_timeout}), 32'd0);
    chk("last.rsp_data", io.rsp_data, 32'h0BAD_F00D);
    $display("op last_cycle_ack rsp=%h", io.rsp_data);
    @(negedge clk);

    // Reset after three wait cycles drops mem_req at once and yields no response.
    issue(0, isa_funct3_lw, 32'h0000_0900, 32'h0);
    repeat (3) @(negedge clk);
    chk("rstbus.mem_req_before", 32'(io.mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstbus.mem_req", 32'(io.mem_req), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rstbus.rsp_valid", 32'(io.rsp_valid), 32'd0);
    end
    chk("rstbus.ready", 32'(io.req_ready), 32'd1);
    $display("op reset_mid_bus ready=%b", io.req_ready);
    bus_op("lw_post", 0, isa_funct3_lw, 32'h0000_0A08, 32'h0, 32'h7654_3210, 32'h0000_0A08, 4'hF, 32'h0, 32'h7654_3210);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
